// File: rtl/mem_stage_pkg.sv
// Shared MIPS pipeline definitions for the MEM stage and its neighbours.
package mem_stage_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;
endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, MEM/WB outputs and forwarding loop of the MEM stage.
interface mem_stage_if #(
  parameter int DATA_W = mem_stage_pkg::DATA_W,
  parameter int REG_W  = mem_stage_pkg::REG_W
);
  logic              stall;
  logic              flush;
  logic              exmem_mem_read;
  logic              exmem_mem_write;
  logic              exmem_reg_write;
  logic              exmem_mem_to_reg;
  logic [DATA_W-1:0] exmem_alu_result;
  logic [DATA_W-1:0] exmem_store_data;
  logic [REG_W-1:0]  exmem_rt;
  logic [REG_W-1:0]  exmem_dest;
  logic              forward_m;
  logic              memwb_reg_write;
  logic              memwb_mem_to_reg;
  logic [DATA_W-1:0] memwb_read_data;
  logic [DATA_W-1:0] memwb_alu_result;
  logic [REG_W-1:0]  memwb_rt;
  logic [REG_W-1:0]  memwb_dest;
  logic [DATA_W-1:0] memwb_wb_data;
  logic              mem_fault;

  modport master (
    output stall, flush, exmem_mem_read, exmem_mem_write, exmem_reg_write,
           exmem_mem_to_reg, exmem_alu_result, exmem_store_data, exmem_rt,
           exmem_dest, forward_m,
    input  memwb_reg_write, memwb_mem_to_reg, memwb_read_data, memwb_alu_result,
           memwb_rt, memwb_dest, memwb_wb_data, mem_fault
  );

  modport slave (
    input  stall, flush, exmem_mem_read, exmem_mem_write, exmem_reg_write,
           exmem_mem_to_reg, exmem_alu_result, exmem_store_data, exmem_rt,
           exmem_dest, forward_m,
    output memwb_reg_write, memwb_mem_to_reg, memwb_read_data, memwb_alu_result,
           memwb_rt, memwb_dest, memwb_wb_data, mem_fault
  );
endinterface

// File: rtl/mem_stage_dmem_sp.sv
// Single-port word RAM: synchronous write, combinational read.
module dmem_sp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory access, store-data forwarding and MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = mem_stage_pkg::DATA_W,
  parameter int ADDR_W = 8,
  parameter int REG_W  = mem_stage_pkg::REG_W
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_stage_if.slave bus
);
  mem_ctrl_t         ex_ctrl;
  logic              aligned;
  logic              conflict;
  logic              bad_access;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] sdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rd_next;

  assign ex_ctrl    = '{mem_read:   bus.exmem_mem_read,
                        mem_write:  bus.exmem_mem_write,
                        reg_write:  bus.exmem_reg_write,
                        mem_to_reg: bus.exmem_mem_to_reg};
  assign waddr      = bus.exmem_alu_result[ADDR_W+1:2];
  assign aligned    = (bus.exmem_alu_result[1:0] == 2'b00);
  assign conflict   = ex_ctrl.mem_read & ex_ctrl.mem_write;
  assign bad_access = (ex_ctrl.mem_read | ex_ctrl.mem_write) & (~aligned | conflict);
  // Forward from the load currently sitting in MEM/WB (lw-then-sw).
  assign sdata      = bus.forward_m ? bus.memwb_wb_data : bus.exmem_store_data;
  // rst_n gating drops a write that coincides with reset.
  assign we         = ex_ctrl.mem_write & ~ex_ctrl.mem_read & aligned & ~bus.stall & rst_n;
  assign rd_next    = (ex_ctrl.mem_read & ~ex_ctrl.mem_write & aligned) ? rdata : '0;

  dmem_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dmem (
    .clk   (clk),
    .we    (we),
    .addr  (waddr),
    .wdata (sdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.memwb_reg_write  <= 1'b0;
      bus.memwb_mem_to_reg <= 1'b0;
      bus.memwb_read_data  <= '0;
      bus.memwb_alu_result <= '0;
      bus.memwb_rt         <= '0;
      bus.memwb_dest       <= '0;
      bus.mem_fault        <= 1'b0;
    end else if (!bus.stall) begin
      if (bad_access) bus.mem_fault <= 1'b1;
      if (bus.flush) begin
        bus.memwb_reg_write  <= 1'b0;
        bus.memwb_mem_to_reg <= 1'b0;
        bus.memwb_read_data  <= '0;
        bus.memwb_alu_result <= '0;
        bus.memwb_rt         <= '0;
        bus.memwb_dest       <= '0;
      end else begin
        bus.memwb_reg_write  <= ex_ctrl.reg_write;
        bus.memwb_mem_to_reg <= ex_ctrl.mem_to_reg;
        bus.memwb_read_data  <= rd_next;
        bus.memwb_alu_result <= bus.exmem_alu_result;
        bus.memwb_rt         <= bus.exmem_rt;
        bus.memwb_dest       <= bus.exmem_dest;
      end
    end
  end

  assign bus.memwb_wb_data = bus.memwb_mem_to_reg ? bus.memwb_read_data : bus.memwb_alu_result;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a word-array reference model checked every cycle.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;

  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: memory as an array of words, MEM/WB as plain variables.
  logic [31:0] mdl_mem [256];
  logic        m_rw = 0, m_mtr = 0, m_fault = 0;
  logic [31:0] m_rd = 0, m_alu = 0;
  logic [4:0]  m_rt = 0, m_dest = 0;
  wire  [31:0] m_wb = m_mtr ? m_rd : m_alu;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rw = 0; m_mtr = 0; m_rd = 0; m_alu = 0; m_rt = 0; m_dest = 0; m_fault = 0;
    end else if (!bus.stall) begin
      automatic int unsigned wa = (bus.exmem_alu_result / 4) % 256;
      automatic bit ok = (bus.exmem_alu_result % 4) == 0;
      automatic bit rd = bus.exmem_mem_read, wr = bus.exmem_mem_write;
      automatic logic [31:0] sd = bus.forward_m ? m_wb : bus.exmem_store_data;
      automatic logic [31:0] ld = (rd && !wr && ok) ? mdl_mem[wa] : 32'h0;
      if ((rd || wr) && (!ok || (rd && wr))) m_fault = 1;
      if (wr && !rd && ok) mdl_mem[wa] = sd;
      if (bus.flush) begin
        m_rw = 0; m_mtr = 0; m_rd = 0; m_alu = 0; m_rt = 0; m_dest = 0;
      end else begin
        m_rw = bus.exmem_reg_write; m_mtr = bus.exmem_mem_to_reg; m_rd = ld;
        m_alu = bus.exmem_alu_result; m_rt = bus.exmem_rt; m_dest = bus.exmem_dest;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_reg_write", 32'(bus.memwb_reg_write), 32'(m_rw));
      chk("m_mem_to_reg", 32'(bus.memwb_mem_to_reg), 32'(m_mtr));
      chk("m_read_data", bus.memwb_read_data, m_rd);
      chk("m_alu_result", bus.memwb_alu_result, m_alu);
      chk("m_rt", 32'(bus.memwb_rt), 32'(m_rt));
      chk("m_dest", 32'(bus.memwb_dest), 32'(m_dest));
      chk("m_wb_data", bus.memwb_wb_data, m_wb);
      chk("m_fault", 32'(bus.mem_fault), 32'(m_fault));
    end
  end

  task automatic drive(input bit rd, wr, rw, mtr, input logic [31:0] alu, sd,
                       input logic [4:0] rt, dest, input bit fwd, st, fl);
    bus.exmem_mem_read = rd; bus.exmem_mem_write = wr;
    bus.exmem_reg_write = rw; bus.exmem_mem_to_reg = mtr;
    bus.exmem_alu_result = alu; bus.exmem_store_data = sd;
    bus.exmem_rt = rt; bus.exmem_dest = dest;
    bus.forward_m = fwd; bus.stall = st; bus.flush = fl;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic sw(input logic [31:0] a, d, input bit fwd = 0, st = 0);
    drive(0, 1, 0, 0, a, d, 5'd0, 5'd0, fwd, st, 0);
  endtask

  task automatic lw(input logic [31:0] a, input logic [4:0] rt, dest);
    drive(1, 0, 1, 1, a, 32'h0, rt, dest, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rw"}, 32'(bus.memwb_reg_write), 0);
    chk({tag, "_mtr"}, 32'(bus.memwb_mem_to_reg), 0);
    chk({tag, "_rd"}, bus.memwb_read_data, 0);
    chk({tag, "_alu"}, bus.memwb_alu_result, 0);
    chk({tag, "_rt"}, 32'(bus.memwb_rt), 0);
    chk({tag, "_dest"}, 32'(bus.memwb_dest), 0);
    chk({tag, "_wb"}, bus.memwb_wb_data, 0);
    chk({tag, "_fault"}, 32'(bus.mem_fault), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk_zero("reset");
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

    // store then load
    sw(32'h10, 32'hDEADBEEF); step();
    lw(32'h10, 5'd2, 5'd8); step();
    chk("sl_rd", bus.memwb_read_data, 32'hDEADBEEF);
    chk("sl_wb", bus.memwb_wb_data, 32'hDEADBEEF);
    chk("sl_dest", 32'(bus.memwb_dest), 8);

    // lw-then-sw forwarding, forward_m = 1
    sw(32'h40, 32'h12345678); step();
    lw(32'h40, 5'd1, 5'd1); step();
    chk("fw_ld_wb", bus.memwb_wb_data, 32'h12345678);
    chk("fw_ld_rt", 32'(bus.memwb_rt), 1);
    sw(32'h20, 32'h0, 1); step();
    lw(32'h20, 5'd2, 5'd2); step();
    chk("fw1_rd", bus.memwb_read_data, 32'h12345678);

    // same sequence, forward_m = 0
    lw(32'h40, 5'd1, 5'd1); step();
    sw(32'h20, 32'h0, 0); step();
    lw(32'h20, 5'd2, 5'd2); step();
    chk("fw0_wb", bus.memwb_wb_data, 32'h0);

    // stalled store waits for release
    sw(32'h30, 32'h11111111); step();
    sw(32'h30, 32'hAAAA5555, 0, 1); step();
    chk("stall_mem1", dut.u_dmem.mem[12], 32'h11111111);
    step();
    chk("stall_mem2", dut.u_dmem.mem[12], 32'h11111111);
    sw(32'h30, 32'hAAAA5555); step();
    chk("release_mem", dut.u_dmem.mem[12], 32'hAAAA5555);
    lw(32'h30, 5'd3, 5'd3); step();
    chk("release_rd", bus.memwb_read_data, 32'hAAAA5555);

    // stall beats flush
    drive(0, 0, 1, 0, 32'h99, 0, 5'd6, 5'd7, 0, 1, 1); step();
    chk("sf_rd", bus.memwb_read_data, 32'hAAAA5555);
    chk("sf_dest", 32'(bus.memwb_dest), 3);
    chk("sf_rw", 32'(bus.memwb_reg_write), 1);

    // flush
    drive(0, 0, 1, 0, 32'h55, 0, 5'd4, 5'd9, 0, 0, 1); step();
    chk("fl_rw", 32'(bus.memwb_reg_write), 0);
    chk("fl_dest", 32'(bus.memwb_dest), 0);

    // misaligned store: no write, sticky fault
    chk("pre_fault", 32'(bus.mem_fault), 0);
    sw(32'h13, 32'h77); step();
    chk("mis_fault", 32'(bus.mem_fault), 1);
    lw(32'h10, 5'd4, 5'd4); step();
    chk("mis_nowrite", bus.memwb_read_data, 32'hDEADBEEF);
    chk("mis_sticky", 32'(bus.mem_fault), 1);

    // address wrap
    sw(32'h400, 32'hCAFE0000); step();
    lw(32'h0, 5'd5, 5'd5); step();
    chk("wrap_rd", bus.memwb_read_data, 32'hCAFE0000);

    // read and write together
    drive(1, 1, 1, 1, 32'h10, 32'h5, 5'd1, 5'd1, 0, 0, 0); step();
    chk("conf_rd", bus.memwb_read_data, 32'h0);
    lw(32'h10, 5'd6, 5'd6); step();
    chk("conf_nowrite", bus.memwb_read_data, 32'hDEADBEEF);

    // asynchronous reset mid-cycle
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline MEM stage: takes EX/MEM control and data, performs the data-memory access, and drives the MEM/WB pipeline register.
- Consumes the store-data forward select produced by the memory forwarding unit.
  - When asserted, a store in EX/MEM writes the value just written back by the load in MEM/WB, not the stale EX/MEM store data (lw-then-sw).
- Returns memwb_rt and memwb_wb_data to that forwarding unit, closing the loop.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 8, word-address bits of the internal data memory (depth 2**ADDR_W words).
- REG_W, 5, register-specifier width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold MEM/WB register; block memory write.
- flush  in  1  load a bubble into MEM/WB.
- exmem_mem_read  in  1  load in EX/MEM.
- exmem_mem_write  in  1  store in EX/MEM.
- exmem_reg_write  in  1  instruction writes the register file.
- exmem_mem_to_reg  in  1  write-back source is memory.
- exmem_alu_result  in  DATA_W  byte address, or ALU result.
- exmem_store_data  in  DATA_W  rt value from EX.
- exmem_rt  in  REG_W  rt specifier.
- exmem_dest  in  REG_W  destination register.
- forward_m  in  1  store data select: 1 = memwb_wb_data.
- memwb_reg_write  out  1  registered.
- memwb_mem_to_reg  out  1  registered.
- memwb_read_data  out  DATA_W  registered load data.
- memwb_alu_result  out  DATA_W  registered.
- memwb_rt  out  REG_W  registered; to forwarding unit.
- memwb_dest  out  REG_W  registered.
- memwb_wb_data  out  DATA_W  combinational: memwb_mem_to_reg ? memwb_read_data : memwb_alu_result.
- mem_fault  out  1  sticky misaligned/conflict flag.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All memwb_* registers are 0, so memwb_wb_data = 0.
  - mem_fault = 0.
  - Memory contents are not reset.
  - Reset may assert mid-operation; any write on that edge is lost.
- Word address:
  - waddr = exmem_alu_result[ADDR_W+1:2].
  - Upper address bits are ignored, so addresses wrap modulo depth.
- Aligned access requires exmem_alu_result[1:0] == 0.
- Store data: sdata = forward_m ? memwb_wb_data : exmem_store_data.
  - The selection uses the current MEM/WB contents, before the edge.
- Write: mem[waddr] <= sdata on a rising edge when all of the following hold:
  - exmem_mem_write = 1
  - stall = 0
  - aligned
  - exmem_mem_read = 0
- Read:
  - When exmem_mem_read = 1 and aligned, memwb_read_data <= mem[waddr] at the edge.
  - Load-to-WB latency is 1 cycle.
  - A read one cycle after a write to the same address returns the new data.
- Misaligned load or store:
  - No memory write.
  - memwb_read_data <= 0.
  - mem_fault <= 1 and stays set until reset.
- Read and write both set:
  - No memory write.
  - memwb_read_data <= 0.
  - mem_fault <= 1.
- MEM/WB update priority, evaluated per edge:
  - stall = 1: all memwb_* hold. stall beats flush.
  - Otherwise flush = 1: memwb_reg_write <= 0; memwb_mem_to_reg <= 0; data and specifier fields <= 0.
  - Otherwise: every memwb_* field is loaded from its exmem_* counterpart; memwb_read_data follows the read rules above.
- A stalled store does not write. It writes on the first unstalled edge, and sdata is re-evaluated at that edge.
- forward_m is ignored when exmem_mem_write = 0.

Decomposition:
- Shared pipeline package:
  - DATA_W, REG_W.
  - Opcode constants OP_LW = 6'b100011 and OP_SW = 6'b101011.
  - A mem_ctrl struct typedef {mem_read, mem_write, reg_write, mem_to_reg}.
- One sub-module, dmem_sp: single-port synchronous word RAM.
  - Ports: clk, we, addr, wdata, rdata.
  - Combinational read, registered by the stage.
- MEM/WB register and fault logic stay in mem_stage.

Test Plan:
- Reset: rst_n low mid-cycle -> all memwb_* = 0 and mem_fault = 0 immediately, with no clock edge.
- Store then load:
  - Stimulus: sw addr 0x10, data 0xDEADBEEF; next cycle lw addr 0x10, dest 8.
  - Response: one cycle later memwb_read_data = 0xDEADBEEF, memwb_wb_data = 0xDEADBEEF, memwb_dest = 8.
- lw-then-sw forward:
  - Stimulus: MEM/WB holds a load of 0x12345678 (rt 1); EX/MEM has sw addr 0x20, store_data 0x0, forward_m = 1.
  - Response: a later lw 0x20 returns 0x12345678.
  - Repeat with forward_m = 0: the later lw returns 0x0.
- Stall and flush:
  - Stimulus: sw addr 0x30 with stall = 1 for 2 cycles, then released; also assert stall and flush together.
  - Response: memory at 0x30 unchanged during the stall and written after release; with both asserted, memwb_* hold.
- Flush: flush = 1 with a reg_write instruction in EX/MEM -> next cycle memwb_reg_write = 0 and memwb_dest = 0.
- Faults and wrap:
  - Stimulus: sw addr 0x13; separately sw addr 0x400 with ADDR_W = 8.
  - Response for 0x13: no write, mem_fault = 1, sticky across later good accesses.
  - Response for 0x400: aliases to word 0, so lw 0x0 returns the stored data.
